phase_addr_gen: RTL and testbench

//  Parametrised successor of the fixed 12-bit address generator. A phase

---
 rtl/phase_addr_gen_pkg.sv | 29 ++
 rtl/phase_addr_gen_if.sv | 32 +++
 rtl/phase_addr_gen_step_calc.sv | 78 +++++++
 rtl/phase_addr_gen.sv | 129 ++++++++++++
 tb/tb_phase_addr_gen.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_addr_gen_pkg.sv
// Shared definitions for the phase-accumulator address generator:
// mode and state encodings, direction type and default geometry.
package phase_addr_gen_pkg;

    localparam int DEF_ACC_W  = 24;
    localparam int DEF_ADDR_W = 12;

    // Sequencing modes as seen on the mode input.
    typedef enum logic [1:0] {
        MODE_SAW_UP  = 2'd0,
        MODE_PING    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_SAW_DN  = 2'd3
    } mode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ping-pong travel direction.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/phase_addr_gen_if.sv
// Control/status bundle between the register block (master) and the
// address generator (slave).
interface phase_addr_gen_if
    import phase_addr_gen_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              en;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [ACC_W-1:0]  step;
    logic              step_load;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              wrap;
    logic              done;
    logic              busy;

    modport master (
        output en, start, stop, mode, step, step_load,
        input  address, addr_valid, wrap, done, busy
    );

    modport slave (
        input  en, start, stop, mode, step, step_load,
        output address, addr_valid, wrap, done, busy
    );

endinterface

// File: rtl/phase_addr_gen_step_calc.sv
// Combinational next-accumulator calculation for one advance of the
// phase accumulator in the latched mode. Reports wrap/reversal and the
// one-shot endpoint; the caller decides whether to commit the result.
module phase_addr_gen_step_calc
    import phase_addr_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] step,
    input  dir_e             dir,
    input  mode_e            mode,
    output logic [ACC_W-1:0] acc_next,
    output dir_e             dir_next,
    output logic             wrap,
    output logic             at_end
);

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    logic [ACC_W-1:0] headroom;

    // The extra top bit of sum/diff is the carry/borrow out.
    assign sum      = {1'b0, acc} + {1'b0, step};
    assign diff     = {1'b0, acc} - {1'b0, step};
    assign headroom = ACC_MAX - step;

    // Select the advance rule for the latched mode; defaults hold everything.
    always_comb begin
        acc_next = acc;
        dir_next = dir;
        wrap     = 1'b0;
        at_end   = 1'b0;
        case (mode)
            MODE_SAW_UP: begin
                acc_next = sum[ACC_W-1:0];
                wrap     = sum[ACC_W];
            end
            MODE_SAW_DN: begin
                acc_next = diff[ACC_W-1:0];
                wrap     = diff[ACC_W];
            end
            MODE_PING: begin
                if (dir == DIR_UP) begin
                    if (acc > headroom) begin
                        acc_next = ACC_MAX;
                        dir_next = DIR_DOWN;
                        wrap     = 1'b1;
                    end else begin
                        acc_next = sum[ACC_W-1:0];
                    end
                end else begin
                    if (acc < step) begin
                        acc_next = '0;
                        dir_next = DIR_UP;
                        wrap     = 1'b1;
                    end else begin
                        acc_next = diff[ACC_W-1:0];
                    end
                end
            end
            MODE_ONESHOT: begin
                if (acc > headroom) begin
                    acc_next = ACC_MAX;
                    at_end   = 1'b1;
                end else begin
                    acc_next = sum[ACC_W-1:0];
                end
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/phase_addr_gen.sv
// Phase-accumulator read-address generator. Holds the control FSM and all
// registers; the per-mode arithmetic lives in phase_addr_gen_step_calc.
// The address output is the top ADDR_W bits of the accumulator.
module phase_addr_gen
    import phase_addr_gen_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    phase_addr_gen_if.slave  bus
);

    // One address per clock: step of 1 in the address field.
    localparam logic [ACC_W-1:0] STEP_DEFAULT =
        {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W - ADDR_W);

    state_e           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] step_reg;
    dir_e             dir, dir_nxt;
    mode_e            mode_reg, mode_nxt;
    logic             valid_q, valid_nxt;
    logic             wrap_q, wrap_nxt;
    logic             end_q, end_nxt;

    logic [ACC_W-1:0] calc_acc;
    dir_e             calc_dir;
    logic             calc_wrap;
    logic             calc_end;

    phase_addr_gen_step_calc #(
        .ACC_W (ACC_W)
    ) u_step_calc (
        .acc      (acc),
        .step     (step_reg),
        .dir      (dir),
        .mode     (mode_reg),
        .acc_next (calc_acc),
        .dir_next (calc_dir),
        .wrap     (calc_wrap),
        .at_end   (calc_end)
    );

    // Step register is independent of the FSM and may be loaded in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_reg <= STEP_DEFAULT;
        end else if (bus.step_load) begin
            step_reg <= bus.step;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            dir      <= DIR_UP;
            mode_reg <= MODE_SAW_UP;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            dir      <= dir_nxt;
            mode_reg <= mode_nxt;
            valid_q  <= valid_nxt;
            wrap_q   <= wrap_nxt;
            end_q    <= end_nxt;
        end
    end

    // Next-state logic with stop > start > en priority. end_q marks the
    // cycle showing the final one-shot address so DONE follows it.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        dir_nxt   = dir;
        mode_nxt  = mode_reg;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        end_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!bus.stop && bus.start) begin
                    state_nxt = ST_RUN;
                    acc_nxt   = '0;
                    dir_nxt   = DIR_UP;
                    mode_nxt  = mode_e'(bus.mode);
                    valid_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    acc_nxt   = '0;
                    dir_nxt   = DIR_UP;
                    mode_nxt  = mode_e'(bus.mode);
                    valid_nxt = 1'b1;
                end else if (end_q) begin
                    state_nxt = ST_DONE;
                end else if (bus.en) begin
                    acc_nxt   = calc_acc;
                    dir_nxt   = calc_dir;
                    wrap_nxt  = calc_wrap;
                    end_nxt   = calc_end;
                    valid_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.address    = acc[ACC_W-1 -: ADDR_W];
    assign bus.addr_valid = valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_phase_addr_gen.sv
// Self-checking bench for phase_addr_gen (ACC_W=24, ADDR_W=12). Each task
// drives one scenario, pushes the expected outputs for the next cycle and
// compares them against the DUT one negedge later.
module tb_phase_addr_gen;
    import phase_addr_gen_pkg::*;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              valid;
        logic              wrap;
        logic              done;
        logic              busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    obs_t sb[$];
    obs_t got, want;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    phase_addr_gen_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    phase_addr_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic obs_t sample();
        obs_t s;
        s.address = bus.address;
        s.valid   = bus.addr_valid;
        s.wrap    = bus.wrap;
        s.done    = bus.done;
        s.busy    = bus.busy;
        return s;
    endfunction

    function automatic obs_t mk(int a, bit v, bit w, bit d, bit b);
        obs_t s;
        s.address = a[ADDR_W-1:0];
        s.valid   = v;
        s.wrap    = w;
        s.done    = d;
        s.busy    = b;
        return s;
    endfunction

    task automatic drive(bit e, bit s, bit p, logic [1:0] m, bit ld, logic [ACC_W-1:0] st);
        bus.en        = e;
        bus.start     = s;
        bus.stop      = p;
        bus.mode      = m;
        bus.step_load = ld;
        bus.step      = st;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, '0);
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_async got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_idle got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
    endtask

    task automatic test_saw_up();
        drive(1, 1, 0, 0, 0, '0);
        sb.push_back(mk(0, 1, 0, 0, 1));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL saw_up_start got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        drive(1, 0, 0, 0, 0, '0);
        for (int i = 1; i <= 4096; i++) begin
            sb.push_back(mk(i % 4096, 1, i == 4096, 0, 1));
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL saw_up[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
        end
    endtask

    task automatic test_ping_pong();
        int addr_tbl[10] = '{1024, 2048, 3072, 4095, 3071, 2047, 1023, 0, 1024, 2048};
        bit wrap_tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        drive(0, 0, 1, 0, 1, 24'h400000);
        sb.push_back(mk(0, 0, 0, 0, 0));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL ping_stop got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        drive(1, 1, 0, 1, 0, '0);
        sb.push_back(mk(0, 1, 0, 0, 1));
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL ping[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
            drive(1, 0, 0, 1, 0, '0);
            if (i < 10) sb.push_back(mk(addr_tbl[i], 1, wrap_tbl[i], 0, 1));
        end
    endtask

    task automatic test_one_shot();
        int   addr_tbl[4] = '{1024, 2048, 3072, 4095};
        obs_t exp_tbl[8];
        exp_tbl[0] = mk(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) exp_tbl[i+1] = mk(addr_tbl[i], 1, 0, 0, 1);
        exp_tbl[5] = mk(4095, 0, 0, 1, 0);
        exp_tbl[6] = mk(4095, 0, 0, 0, 0);
        exp_tbl[7] = mk(4095, 0, 0, 0, 0);
        drive(1, 1, 0, 2, 0, '0);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(exp_tbl[i]);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL one_shot[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
            // a live mode change must not affect the run in progress
            drive(1, 0, 0, 0, 0, '0);
        end
    endtask

    task automatic test_saw_down_freeze();
        obs_t exp_tbl[11];
        bit   en_tbl[11] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0};
        bit   st_tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_tbl[0]  = mk(4095, 0, 0, 0, 0);
        exp_tbl[1]  = mk(0, 1, 0, 0, 1);
        exp_tbl[2]  = mk(4095, 1, 1, 0, 1);
        exp_tbl[3]  = mk(4094, 1, 0, 0, 1);
        exp_tbl[4]  = mk(4093, 1, 0, 0, 1);
        exp_tbl[5]  = mk(4093, 0, 0, 0, 1);
        exp_tbl[6]  = mk(4093, 0, 0, 0, 1);
        exp_tbl[7]  = mk(4093, 0, 0, 0, 1);
        exp_tbl[8]  = mk(4092, 1, 0, 0, 1);
        exp_tbl[9]  = mk(4091, 1, 0, 0, 1);
        exp_tbl[10] = mk(4091, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            drive(en_tbl[i], st_tbl[i], 0, 3, i == 0, 24'h001000);
            sb.push_back(exp_tbl[i]);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL saw_down[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
        end
    endtask

    task automatic test_start_stop_step_zero();
        obs_t exp_tbl[11];
        exp_tbl[0]  = mk(4091, 0, 0, 0, 0);
        exp_tbl[1]  = mk(4091, 0, 0, 0, 0);
        exp_tbl[2]  = mk(0, 1, 0, 0, 1);
        exp_tbl[3]  = mk(1, 1, 0, 0, 1);
        exp_tbl[4]  = mk(2, 1, 0, 0, 1);
        exp_tbl[5]  = mk(3, 1, 0, 0, 1);
        exp_tbl[6]  = mk(3, 1, 0, 0, 1);
        exp_tbl[7]  = mk(3, 1, 0, 0, 1);
        exp_tbl[8]  = mk(3, 1, 0, 0, 1);
        exp_tbl[9]  = mk(3, 1, 0, 0, 1);
        exp_tbl[10] = mk(4, 1, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:       drive(1, 1, 1, 0, 0, '0);
                2:       drive(1, 1, 0, 0, 0, '0);
                5:       drive(1, 0, 0, 0, 1, '0);
                9:       drive(1, 0, 0, 0, 1, 24'h001000);
                default: drive(1, 0, 0, 0, 0, '0);
            endcase
            sb.push_back(exp_tbl[i]);
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL start_stop[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        // leave a non-default step loaded so reset must restore the default
        drive(1, 0, 0, 0, 1, 24'h400000);
        sb.push_back(mk(5, 1, 0, 0, 1));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL pre_reset got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        drive(1, 0, 0, 0, 0, '0);
        sb.push_back(mk(1029, 1, 0, 0, 1));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL pre_reset_step got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        #3 rst = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_mid_run got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        sb.push_back(mk(0, 0, 0, 0, 0));
        @(negedge clk);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                     got.address, got[3:0], want.address, want[3:0]);
        end
        drive(1, 1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(i, 1, 0, 0, 1));
            @(negedge clk);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL post_reset_run[%0d] got addr=%0d vwdb=%b want addr=%0d vwdb=%b",
                         i, got.address, got[3:0], want.address, want[3:0]);
            end
            drive(1, 0, 0, 0, 0, '0);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_saw_up();
        test_ping_pong();
        test_one_shot();
        test_saw_down_freeze();
        test_start_stop_step_zero();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
